// File: rtl/fetch_if.sv
// fetch_if: fetch-stage ROM port, redirect request and instruction handshake
interface fetch_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 15
);
   logic              en;
   logic              jump_valid;
   logic [ADDR_W-1:0] jump_addr;
   logic [ADDR_W-1:0] rom_addr;
   logic [WIDTH-1:0]  rom_data;
   logic [WIDTH-1:0]  instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   modport master (
      input  en, jump_valid, jump_addr, rom_data, instr_ready,
      output rom_addr, instr, instr_pc, instr_valid
   );
   modport slave (
      output en, jump_valid, jump_addr, rom_data, instr_ready,
      input  rom_addr, instr, instr_pc, instr_valid
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: Hack-style fetch stage with PC, jump flush and one-entry skid buffer
module fetch_unit #(
   parameter int                WIDTH    = 16,
   parameter int                ADDR_W   = 15,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic    clk,
   input  logic    rst_n,
   fetch_if.master bus
);
   logic [ADDR_W-1:0] pc, resp_pc, skid_pc;
   logic [WIDTH-1:0]  skid;
   logic              resp_v, skid_v, stall, issue;

   assign bus.rom_addr = pc;

   // a new read is only launched when its response is guaranteed a home next cycle
   always_comb begin
      stall = bus.instr_valid && !bus.instr_ready;
      issue = bus.en && !skid_v && !stall && !bus.jump_valid;
   end

   // program counter and tracking of the read currently in the ROM
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc      <= RESET_PC;
         resp_v  <= 1'b0;
         resp_pc <= '0;
      end else if (bus.jump_valid) begin
         pc     <= bus.jump_addr;
         resp_v <= 1'b0;
      end else if (issue) begin
         pc      <= pc + 1'b1;
         resp_v  <= 1'b1;
         resp_pc <= pc;
      end else
         resp_v <= 1'b0;

   // route the ROM word to the output or, under backpressure, into the skid slot
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.instr       <= '0;
         bus.instr_pc    <= '0;
         bus.instr_valid <= 1'b0;
         skid            <= '0;
         skid_pc         <= '0;
         skid_v          <= 1'b0;
      end else if (bus.jump_valid) begin
         bus.instr_valid <= 1'b0;
         skid_v          <= 1'b0;
      end else if (resp_v && !stall) begin
         bus.instr       <= bus.rom_data;
         bus.instr_pc    <= resp_pc;
         bus.instr_valid <= 1'b1;
      end else if (resp_v) begin
         skid    <= bus.rom_data;
         skid_pc <= resp_pc;
         skid_v  <= 1'b1;
      end else if (skid_v && !stall) begin
         bus.instr       <= skid;
         bus.instr_pc    <= skid_pc;
         bus.instr_valid <= 1'b1;
         skid_v          <= 1'b0;
      end else if (bus.instr_ready)
         bus.instr_valid <= 1'b0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed checking of fetch_unit against a transaction-level model
module tb_fetch_unit;
   logic clk = 0;
   logic rst_n = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   fetch_if #(.WIDTH(16), .ADDR_W(15)) bus();
   fetch_unit #(.WIDTH(16), .ADDR_W(15), .RESET_PC(15'd0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_fn(input logic [14:0] a);
      return {1'b0, a} ^ 16'hA5A5;
   endfunction

   // synchronous ROM: word for the address seen at the previous edge
   initial bus.rom_data = '0;
   always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // wait for the next word taken downstream and compare its address
   task automatic next_word(input logic [14:0] exp, input string name);
      bit got = 0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (bus.instr_valid && bus.instr_ready) begin
            chk(bus.instr_pc == exp, name, bus.instr_pc, exp);
            got = 1;
         end
         step();
      end
      if (!got) chk(0, {name, "_timeout"}, 0, exp);
   endtask

   // model state: next address the downstream must receive, plus previous-cycle history
   logic [14:0] exp_pc = '0;
   logic [14:0] p_rom = '0, p_jaddr = '0, p_pc = '0;
   logic [15:0] p_instr = '0;
   bit          p_rst_n = 0, p_en = 0, p_ready = 0, p_jump = 0, p_valid = 0;
   int          clean = 0, idle = 0;

   always @(negedge clk) begin
      if (!rst_n || !p_rst_n) begin
         chk(!bus.instr_valid && bus.instr == 0 && bus.instr_pc == 0 && bus.rom_addr == 0,
             "reset_vals", {bus.instr_valid, bus.instr}, 0);
         clean = 0;
         idle = 0;
         exp_pc = '0;
      end else begin
         clean = (p_en && p_ready && !p_jump) ? clean + 1 : 0;
         idle  = (!p_en && p_ready && !p_jump) ? idle + 1 : 0;
         if (bus.instr_valid)
            chk(bus.instr == rom_fn(bus.instr_pc), "data", bus.instr, rom_fn(bus.instr_pc));
         if (p_jump) begin
            chk(bus.rom_addr == p_jaddr, "jump_pc", bus.rom_addr, p_jaddr);
            chk(!bus.instr_valid, "jump_flush", bus.instr_valid, 0);
         end else begin
            if (p_valid && !p_ready)
               chk(bus.instr_valid && bus.instr == p_instr && bus.instr_pc == p_pc,
                   "stall_hold", bus.instr_pc, p_pc);
            if ((p_valid && !p_ready) || !p_en)
               chk(bus.rom_addr == p_rom, "pc_hold", bus.rom_addr, p_rom);
            else if (clean >= 2)
               chk(bus.rom_addr == p_rom + 15'd1, "pc_inc", bus.rom_addr, p_rom + 15'd1);
            else
               chk(bus.rom_addr == p_rom || bus.rom_addr == p_rom + 15'd1, "pc_step", bus.rom_addr, p_rom);
         end
         if (clean >= 3) chk(bus.instr_valid, "throughput", bus.instr_valid, 1);
         if (idle >= 2) chk(!bus.instr_valid, "en_idle", bus.instr_valid, 0);
      end
      if (rst_n && bus.instr_valid && bus.instr_ready) begin
         chk(bus.instr_pc == exp_pc, "order", bus.instr_pc, exp_pc);
         exp_pc = exp_pc + 15'd1;
      end
      if (rst_n && bus.jump_valid) exp_pc = bus.jump_addr;
      p_rst_n = rst_n;
      p_en    = bus.en;
      p_ready = bus.instr_ready;
      p_jump  = bus.jump_valid;
      p_jaddr = bus.jump_addr;
      p_valid = bus.instr_valid;
      p_instr = bus.instr;
      p_pc    = bus.instr_pc;
      p_rom   = bus.rom_addr;
   end

   initial begin
      logic [14:0] r;
      int cnt;
      bus.en = 1;
      bus.instr_ready = 1;
      bus.jump_valid = 0;
      bus.jump_addr = '0;
      // reset and start-up
      repeat (3) begin
         step();
         chk(bus.rom_addr == 0 && !bus.instr_valid && bus.instr == 0, "rst_hold", bus.rom_addr, 0);
      end
      rst_n = 1;
      step();
      chk(!bus.instr_valid, "cyc1_valid", bus.instr_valid, 0);
      step();
      chk(bus.instr_valid && bus.instr == 16'hA5A5 && bus.instr_pc == 0, "cyc2_word", bus.instr, 16'hA5A5);
      next_word(15'd0, "start0");
      next_word(15'd1, "start1");
      next_word(15'd2, "start2");
      next_word(15'd3, "start3");
      // backpressure with skid fill
      chk(bus.instr_pc == 15'd4 && bus.rom_addr == 15'd6, "bp_pre", bus.instr_pc, 4);
      bus.instr_ready = 0;
      repeat (3) begin
         step();
         chk(bus.instr_pc == 15'd4 && bus.instr == 16'hA5A1 && bus.rom_addr == 15'd6, "bp_hold", bus.instr_pc, 4);
      end
      bus.instr_ready = 1;
      next_word(15'd4, "bp4");
      next_word(15'd5, "bp5");
      next_word(15'd6, "bp6");
      next_word(15'd7, "bp7");
      // jump with words in flight
      bus.jump_valid = 1;
      bus.jump_addr = 15'h0100;
      step();
      bus.jump_valid = 0;
      chk(!bus.instr_valid && bus.rom_addr == 15'h0100, "jmp_t", bus.rom_addr, 15'h0100);
      step();
      chk(!bus.instr_valid, "jmp_t1", bus.instr_valid, 0);
      step();
      chk(bus.instr_valid && bus.instr_pc == 15'h0100 && bus.instr == 16'hA4A5, "jmp_t2", bus.instr, 16'hA4A5);
      next_word(15'h0100, "jmp0");
      next_word(15'h0101, "jmp1");
      // jump while stalled with the skid full
      bus.instr_ready = 0;
      step();
      step();
      bus.jump_valid = 1;
      bus.jump_addr = 15'h0020;
      step();
      bus.jump_valid = 0;
      chk(!bus.instr_valid, "jskid_flush", bus.instr_valid, 0);
      bus.instr_ready = 1;
      next_word(15'h0020, "jskid0");
      // address wrap
      bus.jump_valid = 1;
      bus.jump_addr = 15'h7FFE;
      step();
      bus.jump_valid = 0;
      next_word(15'h7FFE, "wrap0");
      next_word(15'h7FFF, "wrap1");
      next_word(15'h0000, "wrap2");
      // run-enable drop: exactly one more word
      bus.en = 0;
      r = bus.rom_addr;
      cnt = 0;
      repeat (6) begin
         step();
         if (bus.instr_valid) cnt++;
      end
      chk(cnt == 1, "en_drop_words", cnt, 1);
      chk(bus.rom_addr == r, "en_drop_pc", bus.rom_addr, r);
      bus.en = 1;
      // asynchronous reset mid-stream
      repeat (4) step();
      @(posedge clk);
      #3 rst_n = 0;
      #1 chk(!bus.instr_valid && bus.instr == 0 && bus.instr_pc == 0 && bus.rom_addr == 0, "async_rst", bus.rom_addr, 0);
      step();
      rst_n = 1;
      next_word(15'd0, "rst_restart");
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bus.en = ($urandom_range(0, 9) != 0);
         bus.instr_ready = ($urandom_range(0, 9) < 7);
         bus.jump_valid = ($urandom_range(0, 19) == 0);
         bus.jump_addr = ($urandom_range(0, 3) == 0) ? 15'h7FFC + 15'($urandom_range(0, 3)) : 15'($urandom);
         rst_n = ($urandom_range(0, 199) != 0);
         step();
      end
      bus.jump_valid = 0;
      rst_n = 1;
      repeat (4) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
